branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 121 ++++++++++++
 tb/tb_branch_resolve.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: evaluates conditions, computes the corrected PC,
// issues redirect/flush to the front end, and keeps branch/mispredict statistics.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic             i_pred_taken,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1_data,
  input  logic             i_clr_cnt,
  output logic             o_br_un,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic             o_misalign,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [2:0]       FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [0:0]  state;
  logic [2:0]  fcnt;

  logic        reserved;
  logic        cond;
  logic        taken;
  logic        mispred;
  logic        accept;
  logic        need;
  logic        misaligned;
  logic [31:0] target;

  always_comb begin
    o_br_un    = (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    reserved   = (i_funct3[2:1] == 2'b01);
    // funct3[2] picks less vs equal, funct3[0] inverts the sense
    cond       = i_funct3[2] ? i_br_less : i_br_equal;
    taken      = !reserved && (cond ^ i_funct3[0]);
    mispred    = i_is_branch && (taken != i_pred_taken);
    accept     = i_valid && (state == IDLE);
    need       = i_is_jal || i_is_jalr || mispred;
    target     = i_pc + 32'd4;
    if (i_is_jalr) begin
      target    = i_rs1_data + i_imm;
      target[0] = 1'b0;
    end else if (i_is_jal || (i_is_branch && taken)) begin
      target = i_pc + i_imm;
    end
    misaligned = (target[1:0] != 2'b00);
  end

  assign o_flush = (state == FLUSH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
    end else if (state == IDLE) begin
      if (accept && need && !misaligned) begin
        state <= FLUSH;
        fcnt  <= FLUSH_LAST;
      end
    end else begin
      if (fcnt == '0) begin
        state <= IDLE;
      end else begin
        fcnt <= fcnt - 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_misalign    <= 1'b0;
      o_illegal     <= 1'b0;
    end else begin
      o_redirect <= accept && need && !misaligned;
      o_misalign <= accept && need && misaligned;
      o_illegal  <= accept && i_is_branch && reserved;
      if (accept && need) begin
        o_redirect_pc <= target;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else if (accept && i_is_branch) begin
      if (o_br_cnt != '1) begin
        o_br_cnt <= o_br_cnt + CNT_ONE;
      end
      if (mispred && (o_mispred_cnt != '1)) begin
        o_mispred_cnt <= o_mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed and randomized checks of branch_resolve against a cycle-level reference model.
module tb_branch_resolve;

  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_branch = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        br_less = 1'b0;
  logic        br_equal = 1'b0;
  logic        pred_taken = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        clr_cnt = 1'b0;

  logic        br_un;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        misalign;
  logic        illegal;
  logic [15:0] br_cnt;
  logic [15:0] mispred_cnt;

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_funct3(funct3), .i_br_less(br_less), .i_br_equal(br_equal),
    .i_pred_taken(pred_taken), .i_pc(pc), .i_imm(imm), .i_rs1_data(rs1),
    .i_clr_cnt(clr_cnt), .o_br_un(br_un), .o_redirect(redirect),
    .o_redirect_pc(redirect_pc), .o_flush(flush), .o_misalign(misalign),
    .o_illegal(illegal), .o_br_cnt(br_cnt), .o_mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: flush cycles remaining (including the current one) and counters
  int flush_left = 0;
  int m_br = 0;
  int m_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f3, input bit l, input bit e);
    case (f3)
      3'd0:          return e;
      3'd1:          return !e;
      3'd4, 3'd6:    return l;
      3'd5, 3'd7:    return !l;
      default:       return 1'b0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ".redirect"}, 32'(redirect), 0);
    chk({tag, ".redirect_pc"}, redirect_pc, 0);
    chk({tag, ".flush"}, 32'(flush), 0);
    chk({tag, ".misalign"}, 32'(misalign), 0);
    chk({tag, ".illegal"}, 32'(illegal), 0);
    chk({tag, ".br_cnt"}, 32'(br_cnt), 0);
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 0);
  endtask

  // kind: 0 = no control-flow instruction, 1 = branch, 2 = jal, 3 = jalr
  task automatic step(input bit v, input int kind, input logic [2:0] f3,
                      input bit l, input bit e, input bit p,
                      input logic [31:0] a_pc, input logic [31:0] a_imm,
                      input logic [31:0] a_rs1, input bit c, input string tag);
    bit          acc, tk, nd, mis, ill, exp_redir, exp_mis;
    logic [31:0] tgt;
    valid = v; is_branch = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
    funct3 = f3; br_less = l; br_equal = e; pred_taken = p;
    pc = a_pc; imm = a_imm; rs1 = a_rs1; clr_cnt = c;
    #1;
    chk({tag, ".br_un"}, 32'(br_un), 32'(f3 == 3'd6 || f3 == 3'd7));

    acc = v && (flush_left == 0);
    tk  = (kind == 1) && ref_taken(f3, l, e);
    nd  = (kind == 2) || (kind == 3) || ((kind == 1) && (tk != p));
    if (kind == 3)                 tgt = (a_rs1 + a_imm) & 32'hFFFF_FFFE;
    else if (kind == 2 || tk)      tgt = a_pc + a_imm;
    else                           tgt = a_pc + 32'd4;
    mis = (tgt % 4) != 0;
    ill = (kind == 1) && (f3 == 3'd2 || f3 == 3'd3);
    exp_redir = acc && nd && !mis;
    exp_mis   = acc && nd && mis;

    if (c) begin
      m_br = 0; m_mis = 0;
    end else if (acc && kind == 1) begin
      if (m_br < 65535) m_br++;
      if (tk != p && m_mis < 65535) m_mis++;
    end
    if (exp_redir) flush_left = FC;
    else if (flush_left > 0) flush_left--;

    @(posedge clk); #1;
    chk({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
    chk({tag, ".misalign"}, 32'(misalign), 32'(exp_mis));
    chk({tag, ".illegal"}, 32'(illegal), 32'(acc && ill));
    chk({tag, ".flush"}, 32'(flush), 32'(flush_left > 0));
    chk({tag, ".br_cnt"}, 32'(br_cnt), 32'(m_br));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(m_mis));
    if (exp_redir || exp_mis) chk({tag, ".redirect_pc"}, redirect_pc, tgt);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    flush_left = 0; m_br = 0; m_mis = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check_all_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken
    step(1, 1, 3'd0, 0, 1, 0, 32'h100, 32'h20, 32'h0, 0, "beq");
    chk("beq.pc", redirect_pc, 32'h120);
    idle("beq.f1");
    idle("beq.f2");

    // BLTU correctly predicted taken
    step(0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, "clr1");
    step(1, 1, 3'd6, 1, 0, 1, 32'h200, 32'h40, 32'h0, 0, "bltu");
    chk("bltu.br_cnt", 32'(br_cnt), 1);
    chk("bltu.mis_cnt", 32'(mispred_cnt), 0);

    // JALR wraps and clears bit 0
    step(1, 3, 3'd0, 0, 0, 0, 32'h300, 32'h6, 32'hFFFF_FFFF, 0, "jalr");
    chk("jalr.pc", redirect_pc, 32'h4);
    idle("jalr.f1");
    idle("jalr.f2");

    // Misaligned taken BNE
    step(0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, "clr2");
    step(1, 1, 3'd1, 0, 0, 0, 32'h100, 32'h2, 32'h0, 0, "bne_mis");
    chk("bne_mis.mis_cnt", 32'(mispred_cnt), 1);
    idle("bne_mis.after");

    // Reserved funct3 raises illegal, resolves not-taken
    step(1, 1, 3'd2, 1, 1, 0, 32'h400, 32'h10, 32'h0, 0, "rsvd");

    // Instructions held through FLUSH are ignored; acceptance resumes after IDLE
    step(1, 1, 3'd5, 0, 0, 0, 32'h500, 32'h80, 32'h0, 0, "hold.br");
    step(1, 2, 3'd0, 0, 0, 0, 32'h600, 32'h40, 32'h0, 0, "hold.f1");
    step(1, 2, 3'd0, 0, 0, 0, 32'h600, 32'h40, 32'h0, 0, "hold.f2");
    step(1, 2, 3'd0, 0, 0, 0, 32'h600, 32'h40, 32'h0, 0, "hold.acc");
    chk("hold.acc.pc", redirect_pc, 32'h640);
    idle("hold.d1");
    idle("hold.d2");

    // Reset asserted in the second FLUSH cycle
    step(1, 1, 3'd4, 1, 0, 0, 32'h700, 32'h20, 32'h0, 0, "rst.br");
    step(1, 1, 3'd4, 1, 0, 0, 32'h700, 32'h20, 32'h0, 0, "rst.f1");
    do_reset("rst_mid");
    step(1, 2, 3'd0, 0, 0, 0, 32'h800, 32'h8, 32'h0, 0, "post_rst");
    idle("post_rst.f1");
    idle("post_rst.f2");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int          kind;
      logic [31:0] r_imm;
      kind  = int'($urandom_range(0, 3));
      r_imm = $urandom;
      if (kind != 3) r_imm = r_imm & 32'hFFFF_FFFC;
      step(($urandom_range(0, 9) < 8), kind, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom & 32'hFFFF_FFFC, r_imm, $urandom,
           ($urandom_range(0, 49) == 0), "rnd");
    end

    // Counter saturation
    do_reset("sat_rst");
    valid = 1; is_branch = 1; is_jal = 0; is_jalr = 0; funct3 = 3'd0;
    br_equal = 1; br_less = 0; pred_taken = 1; pc = 32'h1000; imm = 32'h8; clr_cnt = 0;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    m_br = 65534;
    chk("sat.preload", 32'(br_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++)
      step(1, 1, 3'd0, 0, 1, 1, 32'h1000, 32'h8, 32'h0, 0, "sat");
    chk("sat.hold", 32'(br_cnt), 32'h0000_FFFF);
    step(1, 1, 3'd0, 0, 1, 0, 32'h1000, 32'h8, 32'h0, 1, "clr_pri");
    chk("clr_pri.br", 32'(br_cnt), 0);
    chk("clr_pri.mis", 32'(mispred_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
